// File: rtl/dmux_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmux_stream_pkg
// Purpose  : Shared types and helpers for the dmux_stream slice.
// Revision : 1.0  initial release
// ============================================================================
package dmux_stream_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } chan_state_e;

  localparam int DEF_WIDTH = 16;

  // Default buffer entry; the top overrides it with its own WIDTH-bit word.
  typedef logic [DEF_WIDTH-1:0] entry_t;

  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmux_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : dmux_stream_if
// Purpose  : Input stream and per-channel output streams of dmux_stream.
//            in_bcast exists only when DMUX_STREAM_BCAST_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface dmux_stream_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
`ifdef DMUX_STREAM_BCAST_EN
  logic                      in_bcast;
`endif
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic                      sel_err;

  modport master (
`ifdef DMUX_STREAM_BCAST_EN
    output in_bcast,
`endif
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
`ifdef DMUX_STREAM_BCAST_EN
    input  in_bcast,
`endif
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface
`default_nettype wire

// File: rtl/dmux_stream_skid.sv
`default_nettype none
// ============================================================================
// Module   : dmux_stream_skid
// Purpose  : One output channel: 2-entry FIFO skid buffer with its FSM.
// Revision : 1.0  initial release
// ============================================================================
module dmux_stream_skid
  import dmux_stream_pkg::*;
#(
  parameter type ENTRY_T = entry_t
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  ENTRY_T      i_push_data,
  input  logic        i_out_ready,
  output logic        o_out_valid,
  output ENTRY_T      o_out_data,
  output chan_state_e o_state
);

  chan_state_e r_state;
  chan_state_e w_next;
  ENTRY_T      r_head;
  ENTRY_T      r_tail;
  logic        w_pop;

  assign w_pop = (r_state != ST_EMPTY) && i_out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: if (i_push) w_next = ST_ONE;
      ST_ONE: begin
        if (i_push && !w_pop)      w_next = ST_TWO;
        else if (!i_push && w_pop) w_next = ST_EMPTY;
      end
      ST_TWO:   if (w_pop) w_next = ST_ONE;
      default:  w_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    o_out_valid = (r_state != ST_EMPTY);
    o_out_data  = o_out_valid ? r_head : '0;
    o_state     = r_state;
  end

  // On push+pop in ONE the incoming word goes straight to the head slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (w_pop) begin
      if (r_state == ST_TWO) r_head <= r_tail;
      else if (i_push)       r_head <= i_push_data;
    end else if (i_push) begin
      if (r_state == ST_EMPTY) r_head <= i_push_data;
      else                     r_tail <= i_push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmux_stream.sv
`default_nettype none
// ============================================================================
// Module   : dmux_stream
// Purpose  : Registered 1-to-CHANNELS stream demux with per-channel skid
//            buffers. Optional broadcast input: DMUX_STREAM_BCAST_EN.
// Revision : 1.0  initial release
// ============================================================================
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
)(
  input  logic         clk,
  input  logic         reset,
  dmux_stream_if.slave bus
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0] c_chan_cnt = (SEL_W+1)'(CHANNELS);

  typedef logic [WIDTH-1:0] word_t;

  logic                w_bcast;
  logic                w_sel_ok;
  logic                w_in_ready;
  logic                w_xfer;
  logic                r_sel_err;
  logic [CHANNELS-1:0] w_dec;
  logic [CHANNELS-1:0] w_full;

`ifdef DMUX_STREAM_BCAST_EN
  assign w_bcast = bus.in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  assign w_sel_ok   = ({1'b0, bus.in_sel} < c_chan_cnt);
  // Out-of-range selects decode to no channel, so they are always ready.
  assign w_in_ready = w_bcast ? ~|w_full : ~|(w_dec & w_full);
  assign w_xfer     = bus.in_valid && w_in_ready;

  assign bus.in_ready = w_in_ready;
  assign bus.sel_err  = r_sel_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_sel_err <= 1'b0;
    else if (w_xfer && !w_bcast && !w_sel_ok)  r_sel_err <= 1'b1;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    localparam logic [SEL_W-1:0] c_idx = SEL_W'(k);

    chan_state_e w_state;
    word_t       w_lane;
    logic        w_valid;
    logic        w_push;

    assign w_dec[k]  = (bus.in_sel == c_idx);
    assign w_full[k] = (w_state == ST_TWO);
    assign w_push    = w_xfer && (w_bcast || w_dec[k]);

    dmux_stream_skid #(
      .ENTRY_T (word_t)
    ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (bus.in_data),
      .i_out_ready (bus.out_ready[k]),
      .o_out_valid (w_valid),
      .o_out_data  (w_lane),
      .o_state     (w_state)
    );

    assign bus.out_valid[k]                             = w_valid;
    assign bus.out_data[lane_lsb(k, WIDTH) +: WIDTH]    = w_lane;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmux_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dmux_stream
// Purpose  : Self-checking bench for dmux_stream (4-channel and 3-channel).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmux_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmux_stream_if #(.WIDTH(16), .CHANNELS(4)) bus4 ();
  dmux_stream_if #(.WIDTH(16), .CHANNELS(3)) bus3 ();

  dmux_stream #(.WIDTH(16), .CHANNELS(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  dmux_stream #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model for the 4-channel instance: each channel is a FIFO of
  // at most two words, mq[k][0] being the oldest.
  int          mcnt [4];
  logic [15:0] mq   [4][2];
  logic        rb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
  endtask

  // One clock of the 4-channel DUT: drive, check against model, advance model.
  task automatic cycle4(input logic v, input logic [1:0] sel, input logic [15:0] d,
                        input logic [3:0] ordy, input logic bc);
    logic rdy;
    logic acc;
    @(negedge clk);
    bus4.in_valid  = v;
    bus4.in_sel    = sel;
    bus4.in_data   = d;
    bus4.out_ready = ordy;
`ifdef DMUX_STREAM_BCAST_EN
    bus4.in_bcast  = bc;
`endif
    #1;
    rdy = 1'b1;
    for (int k = 0; k < 4; k++)
      if ((bc || int'(sel) == k) && mcnt[k] == 2) rdy = 1'b0;
    check("in_ready", bus4.in_ready, rdy);
    check("sel_err4", bus4.sel_err, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out_valid[%0d]", k), bus4.out_valid[k], mcnt[k] > 0);
      check($sformatf("out_data[%0d]", k), bus4.out_data[k*16 +: 16],
            (mcnt[k] > 0) ? mq[k][0] : 16'h0);
    end
    acc = v && rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (mcnt[k] > 0 && ordy[k]) begin
        mq[k][0] = mq[k][1];
        mcnt[k]--;
      end
    if (acc)
      for (int k = 0; k < 4; k++)
        if (bc || int'(sel) == k) begin
          mq[k][mcnt[k]] = d;
          mcnt[k]++;
        end
  endtask

  initial begin
    reset = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_sel = '0; bus4.in_data = '0; bus4.out_ready = '0;
    bus3.in_valid = 1'b0; bus3.in_sel = '0; bus3.in_data = '0; bus3.out_ready = '0;
`ifdef DMUX_STREAM_BCAST_EN
    bus4.in_bcast = 1'b0;
    bus3.in_bcast = 1'b0;
`endif
    model_clear();
    #1 reset = 1'b1;

    // Reset values
    #12;
    check("rst_valid4", bus4.out_valid, 0);
    check("rst_data4",  bus4.out_data, 0);
    check("rst_ready4", bus4.in_ready, 1);
    check("rst_err4",   bus4.sel_err, 0);
    check("rst_valid3", bus3.out_valid, 0);
    check("rst_err3",   bus3.sel_err, 0);
    @(negedge clk);
    reset = 1'b0;

    // Unicast steering, all consumers ready
    cycle4(1'b1, 2'd0, 16'h1111, 4'hF, 1'b0);
    cycle4(1'b1, 2'd1, 16'h2222, 4'hF, 1'b0);
    check("steer_ch0", bus4.out_data[15:0], 16'h1111);
    cycle4(1'b1, 2'd2, 16'h3333, 4'hF, 1'b0);
    cycle4(1'b1, 2'd3, 16'h4444, 4'hF, 1'b0);
    cycle4(1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);
    check("steer_ch3", bus4.out_data[63:48], 16'h4444);

    // Back-pressure on channel 1
    cycle4(1'b1, 2'd1, 16'hA001, 4'b1101, 1'b0);
    cycle4(1'b1, 2'd1, 16'hA002, 4'b1101, 1'b0);
    cycle4(1'b1, 2'd1, 16'hA003, 4'b1101, 1'b0);
    check("bp_stall", bus4.in_ready, 0);
    cycle4(1'b1, 2'd0, 16'h0B0B, 4'b1101, 1'b0);
    check("bp_other", bus4.in_ready, 1);
    cycle4(1'b1, 2'd1, 16'hA003, 4'hF, 1'b0);
    check("bp_head1", bus4.out_data[31:16], 16'hA001);
    cycle4(1'b1, 2'd1, 16'hA003, 4'hF, 1'b0);
    check("bp_head2", bus4.out_data[31:16], 16'hA002);
    cycle4(1'b0, 2'd1, 16'h0000, 4'hF, 1'b0);
    check("bp_head3", bus4.out_data[31:16], 16'hA003);

    // Simultaneous push/pop on channel 3
    cycle4(1'b1, 2'd3, 16'hBEEF, 4'h0, 1'b0);
    cycle4(1'b1, 2'd3, 16'hCAFE, 4'h8, 1'b0);
    cycle4(1'b0, 2'd3, 16'h0000, 4'h0, 1'b0);
    check("pp_head", bus4.out_data[63:48], 16'hCAFE);
    cycle4(1'b0, 2'd0, 16'h0000, 4'h0, 1'b0);

    // Out-of-range select on the 3-channel instance
    @(negedge clk);
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_data = 16'h5555; bus3.out_ready = 3'b111;
    #1 check("bad_ready", bus3.in_ready, 1);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    #1;
    check("bad_valid", bus3.out_valid, 0);
    check("bad_data",  bus3.out_data, 0);
    check("bad_err",   bus3.sel_err, 1);
    @(negedge clk);
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd2; bus3.in_data = 16'h3C3C; bus3.out_ready = 3'b000;
    @(negedge clk);
    bus3.in_valid = 1'b0;
    #1;
    check("ch3_valid", bus3.out_valid, 3'b100);
    check("ch3_data",  bus3.out_data[47:32], 16'h3C3C);
    repeat (3) @(negedge clk);
    check("bad_err_hold", bus3.sel_err, 1);

    // Asynchronous reset while channel 2 holds two words
    cycle4(1'b1, 2'd2, 16'h2A01, 4'h0, 1'b0);
    cycle4(1'b1, 2'd2, 16'h2A02, 4'h0, 1'b0);
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.in_sel = 2'd2; bus4.in_data = 16'h2A03;
    #1 check("pre_rst_ready", bus4.in_ready, 0);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", bus4.out_valid, 0);
    check("arst_data",  bus4.out_data, 0);
    check("arst_ready", bus4.in_ready, 1);
    check("arst_err4",  bus4.sel_err, 0);
    check("arst_err3",  bus3.sel_err, 0);
    check("arst_valid3", bus3.out_valid, 0);
    model_clear();
    bus4.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

`ifdef DMUX_STREAM_BCAST_EN
    cycle4(1'b1, 2'd2, 16'h7777, 4'h0, 1'b1);
    cycle4(1'b0, 2'd0, 16'h0000, 4'h0, 1'b0);
    check("bc_valid", bus4.out_valid, 4'hF);
    cycle4(1'b1, 2'd0, 16'h1234, 4'h0, 1'b0);
    cycle4(1'b1, 2'd1, 16'h5678, 4'h0, 1'b1);
    check("bc_full", bus4.in_ready, 0);
    cycle4(1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);
    cycle4(1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rb = 1'b0;
`ifdef DMUX_STREAM_BCAST_EN
      rb = ($urandom_range(7) == 0);
`endif
      cycle4($urandom_range(3) != 0, 2'($urandom_range(3)), 16'($urandom),
             4'($urandom), rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
